// File: rtl/quidditch_pkg.sv
// Shared screen constants, RGB332 colours and beam-coordinate types for the
// pixel-domain sprite stages.
package quidditch_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [7:0] RGB_BLACK  = 8'h00;
    localparam logic [7:0] RGB_YELLOW = 8'hFC;

    typedef logic [9:0] coord_x_t;
    typedef logic [8:0] coord_y_t;

endpackage

// File: rtl/snitch_sprite_mover_if.sv
// Timing-generator inputs and sprite outputs of the snitch mover, bundled.
// Strobe semantics: pixelstb qualifies actv/ox/oy; anm is sampled only with pixelstb.
interface snitch_sprite_mover_if;

    logic                     pixelstb;
    logic                     actv;
    logic                     anm;
    quidditch_pkg::coord_x_t  ox;
    quidditch_pkg::coord_y_t  oy;
    logic                     freeze;
    quidditch_pkg::coord_x_t  spr_x;
    quidditch_pkg::coord_y_t  spr_y;
    logic                     pix_on;
    logic [7:0]               rgb;
    logic                     bounce;
    logic [7:0]               bounce_cnt;

    modport master (
        output pixelstb, actv, anm, ox, oy, freeze,
        input  spr_x, spr_y, pix_on, rgb, bounce, bounce_cnt
    );

    modport slave (
        input  pixelstb, actv, anm, ox, oy, freeze,
        output spr_x, spr_y, pix_on, rgb, bounce, bounce_cnt
    );

endinterface

// File: rtl/sprite_axis_bounce.sv
// One axis of the bouncing sprite: position, direction, step and wall clamp.
// With SNITCH_JITTER_EN the step is re-latched as STEP + i_jit on each bounce.
module sprite_axis_bounce #(
    parameter int W     = 10,
    parameter int LIM   = 624,
    parameter int START = 312,
    parameter int STEP  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_upd,
`ifdef SNITCH_JITTER_EN
    input  logic         i_jit,
`endif
    output logic [W-1:0] o_pos,
    output logic         o_hit
);

    localparam int WP = W + 1;

    logic [W-1:0] r_pos;
    logic         r_dir;      // 0 = towards LIM, 1 = towards 0
    logic [4:0]   w_step;
    logic [W:0]   w_sum;
    logic [W-1:0] w_pos_nxt;

`ifdef SNITCH_JITTER_EN
    logic [4:0] r_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step <= 5'(STEP);
        end else if (i_upd && o_hit) begin
            r_step <= 5'(STEP) + {4'd0, i_jit};
        end
    end

    assign w_step = r_step;
`else
    assign w_step = 5'(STEP);
`endif

    // One extra bit so position + step never wraps before the limit compare.
    assign w_sum = WP'(r_pos) + WP'(w_step);

    always_comb begin
        o_hit     = 1'b0;
        w_pos_nxt = r_pos;
        if (!r_dir) begin
            if (w_sum >= WP'(LIM)) begin
                o_hit     = 1'b1;
                w_pos_nxt = W'(LIM);
            end else begin
                w_pos_nxt = w_sum[W-1:0];
            end
        end else begin
            if (WP'(r_pos) <= WP'(w_step)) begin
                o_hit     = 1'b1;
                w_pos_nxt = '0;
            end else begin
                w_pos_nxt = r_pos - W'(w_step);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos <= W'(START);
            r_dir <= 1'b0;
        end else if (i_upd) begin
            r_pos <= w_pos_nxt;
            if (o_hit) begin
                r_dir <= ~r_dir;
            end
        end
    end

    assign o_pos = r_pos;

endmodule

// File: rtl/snitch_sprite_mover.sv
// Bouncing snitch sprite: steps once per frame on anm and renders a rounded
// 16x16 ball per pixel. Optional step jitter via macro SNITCH_JITTER_EN.
module snitch_sprite_mover
    import quidditch_pkg::*;
#(
    parameter int         SPR_W   = 16,
    parameter int         SPR_H   = 16,
    parameter int         SCR_W   = SCREEN_W,
    parameter int         SCR_H   = SCREEN_H,
    parameter int         START_X = 312,
    parameter int         START_Y = 232,
    parameter int         VX      = 2,
    parameter int         VY      = 1,
    parameter logic [7:0] COLOR   = RGB_YELLOW
) (
    input  logic                  vgaclk,
    input  logic                  inputreset,
    snitch_sprite_mover_if.slave  bus
);

    logic       w_upd;
    logic       w_hit_x;
    logic       w_hit_y;
    coord_x_t   w_spr_x;
    coord_y_t   w_spr_y;
    logic       r_bounce;
    logic [7:0] r_bounce_cnt;

    // anm only changes on pixelstb, so this fires exactly once per frame.
    assign w_upd = bus.anm & bus.pixelstb & ~bus.freeze;

`ifdef SNITCH_JITTER_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge vgaclk or posedge inputreset) begin
        if (inputreset) begin
            r_lfsr <= 8'hA5;
        end else if (w_upd) begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end
`endif

    sprite_axis_bounce #(.W(10), .LIM(SCR_W - SPR_W), .START(START_X), .STEP(VX)) u_axis_x (
        .clk   (vgaclk),
        .rst   (inputreset),
        .i_upd (w_upd),
`ifdef SNITCH_JITTER_EN
        .i_jit (r_lfsr[0]),
`endif
        .o_pos (w_spr_x),
        .o_hit (w_hit_x)
    );

    sprite_axis_bounce #(.W(9), .LIM(SCR_H - SPR_H), .START(START_Y), .STEP(VY)) u_axis_y (
        .clk   (vgaclk),
        .rst   (inputreset),
        .i_upd (w_upd),
`ifdef SNITCH_JITTER_EN
        .i_jit (r_lfsr[1]),
`endif
        .o_pos (w_spr_y),
        .o_hit (w_hit_y)
    );

    // A corner bounce on both axes still counts as a single event.
    always_ff @(posedge vgaclk or posedge inputreset) begin
        if (inputreset) begin
            r_bounce     <= 1'b0;
            r_bounce_cnt <= 8'd0;
        end else begin
            r_bounce <= w_upd & (w_hit_x | w_hit_y);
            if (w_upd && (w_hit_x || w_hit_y)) begin
                r_bounce_cnt <= r_bounce_cnt + 8'd1;
            end
        end
    end

    coord_x_t w_dx;
    coord_y_t w_dy;
    logic     w_in_x;
    logic     w_in_y;
    logic     w_edge_x;
    logic     w_edge_y;
    logic     w_pix_nxt;
    logic     r_pix_on;
    logic [7:0] r_rgb;

    // Pixel test uses the pre-update position; the range checks guard the subtraction.
    assign w_dx      = bus.ox - w_spr_x;
    assign w_dy      = bus.oy - w_spr_y;
    assign w_in_x    = (bus.ox >= w_spr_x) && (w_dx < coord_x_t'(SPR_W));
    assign w_in_y    = (bus.oy >= w_spr_y) && (w_dy < coord_y_t'(SPR_H));
    assign w_edge_x  = (w_dx == '0) || (w_dx == coord_x_t'(SPR_W - 1));
    assign w_edge_y  = (w_dy == '0) || (w_dy == coord_y_t'(SPR_H - 1));
    assign w_pix_nxt = bus.actv & w_in_x & w_in_y & ~(w_edge_x & w_edge_y);

    always_ff @(posedge vgaclk or posedge inputreset) begin
        if (inputreset) begin
            r_pix_on <= 1'b0;
            r_rgb    <= RGB_BLACK;
        end else if (bus.pixelstb) begin
            r_pix_on <= w_pix_nxt;
            r_rgb    <= w_pix_nxt ? COLOR : RGB_BLACK;
        end
    end

    assign bus.spr_x      = w_spr_x;
    assign bus.spr_y      = w_spr_y;
    assign bus.pix_on     = r_pix_on;
    assign bus.rgb        = r_rgb;
    assign bus.bounce     = r_bounce;
    assign bus.bounce_cnt = r_bounce_cnt;

endmodule

// File: tb/tb_snitch_sprite_mover.sv
// Directed bench: default-position, near-right-wall and near-corner instances
// share one stimulus stream; every expected value is hand-computed.
module tb_snitch_sprite_mover;

    logic vgaclk = 1'b0;
    logic inputreset = 1'b1;
    logic pixelstb = 1'b0, actv = 1'b0, anm = 1'b0, freeze = 1'b0;
    logic [9:0] ox = '0;
    logic [8:0] oy = '0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 vgaclk = ~vgaclk;

    snitch_sprite_mover_if if0 ();
    snitch_sprite_mover_if if1 ();
    snitch_sprite_mover_if if2 ();

    assign if0.pixelstb = pixelstb; assign if0.actv = actv; assign if0.anm = anm;
    assign if0.ox = ox; assign if0.oy = oy; assign if0.freeze = freeze;
    assign if1.pixelstb = pixelstb; assign if1.actv = actv; assign if1.anm = anm;
    assign if1.ox = ox; assign if1.oy = oy; assign if1.freeze = freeze;
    assign if2.pixelstb = pixelstb; assign if2.actv = actv; assign if2.anm = anm;
    assign if2.ox = ox; assign if2.oy = oy; assign if2.freeze = freeze;

    snitch_sprite_mover u0 (.vgaclk(vgaclk), .inputreset(inputreset), .bus(if0.slave));
    snitch_sprite_mover #(.START_X(622)) u1 (.vgaclk(vgaclk), .inputreset(inputreset), .bus(if1.slave));
    snitch_sprite_mover #(.START_X(622), .START_Y(463)) u2 (.vgaclk(vgaclk), .inputreset(inputreset), .bus(if2.slave));

    task automatic do_reset();
        @(negedge vgaclk); inputreset = 1'b1;
        @(negedge vgaclk); inputreset = 1'b0;
    endtask

    // One-cycle frame strobe; returns on the negedge right after the update edge.
    task automatic frame();
        @(negedge vgaclk); anm = 1'b1; pixelstb = 1'b1;
        @(negedge vgaclk); anm = 1'b0; pixelstb = 1'b0;
    endtask

    task automatic pix(input logic [9:0] x, input logic [8:0] y, input logic a);
        @(negedge vgaclk); ox = x; oy = y; actv = a; pixelstb = 1'b1;
        @(negedge vgaclk); pixelstb = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (if0.spr_x !== 10'd312) begin n_fail++; $display("FAIL rst_x got=%0d exp=312", if0.spr_x); end
        n_checks++; if (if0.spr_y !== 9'd232) begin n_fail++; $display("FAIL rst_y got=%0d exp=232", if0.spr_y); end
        n_checks++; if (if0.pix_on !== 1'b0 || if0.rgb !== 8'h00) begin n_fail++; $display("FAIL rst_pix got=%b/%h exp=0/00", if0.pix_on, if0.rgb); end
        n_checks++; if (if0.bounce !== 1'b0 || if0.bounce_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_bounce got=%b/%0d exp=0/0", if0.bounce, if0.bounce_cnt); end
        n_checks++; if (if1.spr_x !== 10'd622) begin n_fail++; $display("FAIL rst_x1 got=%0d exp=622", if1.spr_x); end
        n_checks++; if (if2.spr_y !== 9'd463) begin n_fail++; $display("FAIL rst_y2 got=%0d exp=463", if2.spr_y); end
    endtask

    task automatic test_step_and_bounce();
        frame();
        n_checks++; if (if0.spr_x !== 10'd314 || if0.spr_y !== 9'd233) begin n_fail++; $display("FAIL step got=(%0d,%0d) exp=(314,233)", if0.spr_x, if0.spr_y); end
        n_checks++; if (if0.bounce !== 1'b0) begin n_fail++; $display("FAIL step_bounce got=%b exp=0", if0.bounce); end
        n_checks++; if (if1.spr_x !== 10'd624 || if1.bounce !== 1'b1) begin n_fail++; $display("FAIL wall_x got=%0d/%b exp=624/1", if1.spr_x, if1.bounce); end
        n_checks++; if (if2.spr_x !== 10'd624 || if2.spr_y !== 9'd464 || if2.bounce !== 1'b1) begin n_fail++; $display("FAIL corner got=(%0d,%0d)/%b exp=(624,464)/1", if2.spr_x, if2.spr_y, if2.bounce); end
        @(negedge vgaclk);
        n_checks++; if (if1.bounce !== 1'b0 || if1.bounce_cnt !== 8'd1) begin n_fail++; $display("FAIL wall_pulse got=%b/%0d exp=0/1", if1.bounce, if1.bounce_cnt); end
        n_checks++; if (if2.bounce !== 1'b0 || if2.bounce_cnt !== 8'd1) begin n_fail++; $display("FAIL corner_pulse got=%b/%0d exp=0/1", if2.bounce, if2.bounce_cnt); end
    endtask

    task automatic test_anm_hold();
        @(negedge vgaclk); anm = 1'b1; pixelstb = 1'b0;
        @(negedge vgaclk); pixelstb = 1'b1;
        @(negedge vgaclk); pixelstb = 1'b0;
        @(negedge vgaclk);
        @(negedge vgaclk); anm = 1'b0;
        n_checks++; if (if0.spr_x !== 10'd316 || if0.spr_y !== 9'd234) begin n_fail++; $display("FAIL anm_hold got=(%0d,%0d) exp=(316,234)", if0.spr_x, if0.spr_y); end
        n_checks++; if (if1.spr_x !== 10'd622 || if1.bounce_cnt !== 8'd1) begin n_fail++; $display("FAIL wall_back got=%0d/%0d exp=622/1", if1.spr_x, if1.bounce_cnt); end
        n_checks++; if (if2.spr_y !== 9'd463) begin n_fail++; $display("FAIL corner_back_y got=%0d exp=463", if2.spr_y); end
    endtask

    task automatic test_pixel();
        do_reset();
        pix(10'd312, 9'd232, 1'b1);
        n_checks++; if (if0.pix_on !== 1'b0) begin n_fail++; $display("FAIL pix_corner00 got=%b exp=0", if0.pix_on); end
        pix(10'd313, 9'd232, 1'b1);
        n_checks++; if (if0.pix_on !== 1'b1 || if0.rgb !== 8'hFC) begin n_fail++; $display("FAIL pix_in got=%b/%h exp=1/fc", if0.pix_on, if0.rgb); end
        @(negedge vgaclk); ox = 10'd0; oy = 9'd0;
        @(negedge vgaclk);
        n_checks++; if (if0.pix_on !== 1'b1 || if0.rgb !== 8'hFC) begin n_fail++; $display("FAIL pix_hold got=%b/%h exp=1/fc", if0.pix_on, if0.rgb); end
        pix(10'd328, 9'd232, 1'b1);
        n_checks++; if (if0.pix_on !== 1'b0 || if0.rgb !== 8'h00) begin n_fail++; $display("FAIL pix_right got=%b/%h exp=0/00", if0.pix_on, if0.rgb); end
        pix(10'd327, 9'd247, 1'b1);
        n_checks++; if (if0.pix_on !== 1'b0) begin n_fail++; $display("FAIL pix_corner_br got=%b exp=0", if0.pix_on); end
        pix(10'd327, 9'd246, 1'b1);
        n_checks++; if (if0.pix_on !== 1'b1) begin n_fail++; $display("FAIL pix_edge got=%b exp=1", if0.pix_on); end
        pix(10'd311, 9'd240, 1'b1);
        n_checks++; if (if0.pix_on !== 1'b0) begin n_fail++; $display("FAIL pix_left got=%b exp=0", if0.pix_on); end
        pix(10'd320, 9'd240, 1'b0);
        n_checks++; if (if0.pix_on !== 1'b0 || if0.rgb !== 8'h00) begin n_fail++; $display("FAIL pix_inactive got=%b/%h exp=0/00", if0.pix_on, if0.rgb); end
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            frame();
            n_checks++; if (if1.bounce !== 1'b0 || if0.bounce !== 1'b0) begin n_fail++; $display("FAIL frz_bounce got=%b/%b exp=0/0", if0.bounce, if1.bounce); end
        end
        n_checks++; if (if0.spr_x !== 10'd312 || if0.spr_y !== 9'd232) begin n_fail++; $display("FAIL frz_pos got=(%0d,%0d) exp=(312,232)", if0.spr_x, if0.spr_y); end
        n_checks++; if (if1.spr_x !== 10'd622 || if1.bounce_cnt !== 8'd0) begin n_fail++; $display("FAIL frz_wall got=%0d/%0d exp=622/0", if1.spr_x, if1.bounce_cnt); end
        freeze = 1'b0;
        frame();
        n_checks++; if (if0.spr_x !== 10'd314 || if1.spr_x !== 10'd624 || if1.bounce !== 1'b1) begin n_fail++; $display("FAIL unfrz got=%0d/%0d/%b exp=314/624/1", if0.spr_x, if1.spr_x, if1.bounce); end
    endtask

    task automatic test_midframe_reset();
        for (int i = 0; i < 43; i++) frame();
        n_checks++; if (if0.spr_x !== 10'd400 || if0.spr_y !== 9'd276) begin n_fail++; $display("FAIL travel got=(%0d,%0d) exp=(400,276)", if0.spr_x, if0.spr_y); end
        n_checks++; if (if1.spr_x !== 10'd538 || if1.bounce_cnt !== 8'd1) begin n_fail++; $display("FAIL travel_left got=%0d/%0d exp=538/1", if1.spr_x, if1.bounce_cnt); end
        pix(10'd405, 9'd280, 1'b1);
        n_checks++; if (if0.pix_on !== 1'b1) begin n_fail++; $display("FAIL pre_rst_pix got=%b exp=1", if0.pix_on); end
        #2 inputreset = 1'b1;
        #1;
        n_checks++; if (if0.spr_x !== 10'd312 || if0.spr_y !== 9'd232) begin n_fail++; $display("FAIL mid_rst_pos got=(%0d,%0d) exp=(312,232)", if0.spr_x, if0.spr_y); end
        n_checks++; if (if0.pix_on !== 1'b0 || if0.rgb !== 8'h00) begin n_fail++; $display("FAIL mid_rst_pix got=%b/%h exp=0/00", if0.pix_on, if0.rgb); end
        n_checks++; if (if1.bounce_cnt !== 8'd0 || if1.spr_x !== 10'd622) begin n_fail++; $display("FAIL mid_rst_cnt got=%0d/%0d exp=0/622", if1.bounce_cnt, if1.spr_x); end
        @(negedge vgaclk); inputreset = 1'b0;
        frame();
        n_checks++; if (if0.spr_x !== 10'd314 || if0.spr_y !== 9'd233) begin n_fail++; $display("FAIL post_rst_step got=(%0d,%0d) exp=(314,233)", if0.spr_x, if0.spr_y); end
    endtask

    initial begin
        test_reset();
        test_step_and_bounce();
        test_anm_hold();
        test_pixel();
        test_freeze();
        test_midframe_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snitch_sprite_mover.md
Name: snitch_sprite_mover

Overview:
- Pixel-domain stage directly downstream of the VGA timing generator.
- Consumes the timing generator's pixel strobe, active flag, frame-end strobe and ox/oy beam coordinates.
- Keeps a bouncing snitch sprite's position and advances it once per frame.
- Emits a registered per-pixel colour for the colour mux/DAC stage.

Parameters:
- SPR_W, 16, sprite width in pixels
- SPR_H, 16, sprite height in pixels
- SCR_W, 640, active width
- SCR_H, 480, active height
- START_X, 312, reset x position (top-left corner)
- START_Y, 232, reset y position
- VX, 2, x step per frame, 1..15
- VY, 1, y step per frame, 1..15
- COLOR, 8'hFC, RGB332 sprite colour

Ports:
- vgaclk  in  1  system clock
- inputreset  in  1  asynchronous active-high reset
- pixelstb  in  1  pixel-rate enable from timing generator
- actv  in  1  beam inside active area
- anm  in  1  last active line finished (frame-update strobe, may stay high several vgaclk cycles)
- ox  in  10  beam x
- oy  in  9  beam y
- freeze  in  1  hold sprite position (game paused)
- spr_x  out  10  current sprite x
- spr_y  out  9  current sprite y
- pix_on  out  1  current pixel belongs to sprite
- rgb  out  8  pixel colour, 0 when not sprite
- bounce  out  1  one-vgaclk pulse on any wall bounce
- bounce_cnt  out  8  wall-bounce frame count

Behaviour:
- Reset values, asynchronous:
  - spr_x=START_X, spr_y=START_Y.
  - Direction: x right, y down.
  - pix_on=0, rgb=0, bounce=0, bounce_cnt=0.
- Frame update event: upd = anm & pixelstb & ~freeze. Exactly one update per frame, because anm changes only on pixelstb.
- Limits: LIMX = SCR_W-SPR_W (624); LIMY = SCR_H-SPR_H (464).
- X axis, moving right:
  - If x+VX >= LIMX: x<=LIMX, dir<=left, bounce.
  - Else x<=x+VX.
- X axis, moving left:
  - If x <= VX: x<=0, dir<=right, bounce.
  - Else x<=x-VX.
- Y axis: same rules with VY and LIMY.
- Arithmetic: compare in 11-bit (x) / 10-bit (y) so there is no wrap.
- Bounce reporting:
  - bounce pulses the cycle after upd if either axis bounced.
  - A corner (both axes) gives a single pulse and bounce_cnt+1.
  - bounce_cnt wraps 255->0.
- freeze=1: position, direction and bounce_cnt hold; bounce stays 0.
- Pixel stage, updated only when pixelstb=1 (outputs hold otherwise), latency one pixelstb:
  - pix_on <= actv & (ox-spr_x < SPR_W) & (oy-spr_y < SPR_H) & ~corner.
  - corner = the four pixels at relative (0,0), (SPR_W-1,0), (0,SPR_H-1), (SPR_W-1,SPR_H-1) (rounded ball).
  - Use unsigned subtraction with the ox>=spr_x / oy>=spr_y checks explicit.
  - rgb <= pix_on_next ? COLOR : 0.
- Pixel stage uses the position registered before any same-cycle update.
- Reset mid-frame: all state returns to reset values immediately; the next anm performs the first step.

Optional Feature:
- Macro: SNITCH_JITTER_EN.
- Defined:
  - 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'hA5, advances on every upd.
  - After a bounce on an axis, that axis' step becomes base step + lfsr[0] (x) or + lfsr[1] (y), latched until that axis' next bounce.
- Undefined: no LFSR; steps fixed at VX/VY.

Decomposition:
- Package quidditch_pkg:
  - SCR_W/SCR_H constants.
  - RGB332 colour constants.
  - Typedef for 10-bit x coordinate and 9-bit y coordinate.
- Sub-module sprite_axis_bounce:
  - One axis: position, direction, step, limit, bounce flag.
  - Instantiated twice with width parameter 10 and 9.

Test Plan:
- Assert inputreset mid-frame with the sprite at (400,300) -> immediately spr_x=312, spr_y=232, pix_on=0, rgb=0, bounce_cnt=0.
- One anm frame strobe from reset -> spr_x=314, spr_y=233, bounce=0.
- Hold anm high for 4 vgaclk with pixelstb high only 1 of them -> exactly one step.
- START_X=622, one frame:
  - -> spr_x=624, bounce pulses 1 cycle, bounce_cnt=1.
  - Next frame -> spr_x=622.
- START_X=622, START_Y=463, one frame -> spr_x=624, spr_y=464, single bounce pulse, bounce_cnt=1.
- Sprite at (312,232), beam at active (312,232) -> pix_on=0 (corner).
- Beam at (313,232) -> pix_on=1, rgb=8'hFC one pixelstb later.
- Beam at (328,232) -> pix_on=0.
- actv=0 -> rgb=0.
- freeze=1 across 3 frames -> spr_x/spr_y unchanged, bounce never asserts.
